// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation codes, FSM states and small operand helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // One restoring iteration per operand bit.
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Magnitude of a two's-complement word when signed; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bundle. The master is the pipeline side,
// the slave is the sequencer.
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall_o, busy, hilo_we, hi_o, lo_o, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall_o, busy, hilo_we, hi_o, lo_o, div_zero
  );
endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider: one shift-subtract step per cycle on a 64-bit
// {remainder, quotient} register. quo_o/rem_o show the value after the current step.
module div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [63:0] sr_q;
  logic [63:0] sr_d;
  logic [63:0] sr_step;
  logic [31:0] dvs_q;
  logic [31:0] dvs_d;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  // Partial remainder is always below the divisor, so 33 bits hold the shifted value.
  always_comb begin
    rem_sh = {sr_q[63:32], sr_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    if (diff[33]) begin
      sr_step = {rem_sh[31:0], sr_q[30:0], 1'b0};
    end else begin
      sr_step = {diff[31:0], sr_q[30:0], 1'b1};
    end
  end

  always_comb begin
    sr_d  = sr_q;
    dvs_d = dvs_q;
    if (load_i) begin
      sr_d  = {32'd0, dividend_i};
      dvs_d = divisor_i;
    end else if (step_i) begin
      sr_d = sr_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      dvs_q <= '0;
    end else begin
      sr_q  <= sr_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo_o = sr_step[31:0];
  assign rem_o = sr_step[63:32];

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: stalls EX while busy and delivers
// {HI,LO} with a single-cycle write strobe; flush cancels any operation in flight.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mdu_sequencer_if.slave   bus
);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             mul_signed_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             dz_q;

  logic        accept;
  logic        acc_div;
  logic        acc_div_zero;
  logic        signed_div;
  logic [63:0] product;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign accept       = (state_q == ST_IDLE) && bus.start && op_is_valid(bus.op) && !bus.flush;
  assign acc_div      = op_is_div(bus.op);
  assign acc_div_zero = acc_div && (bus.src_b == 32'd0);
  assign signed_div   = (bus.op == MDU_DIV);

  // Sign-extending only for MULT lets one 64-bit multiplier serve both variants.
  assign product = {{32{mul_signed_q & a_q[31]}}, a_q} * {{32{mul_signed_q & b_q[31]}}, b_q};

  div_core u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept && acc_div && !acc_div_zero),
    .step_i     (state_q == ST_DIV),
    .dividend_i (mag32(bus.src_a, signed_div)),
    .divisor_i  (mag32(bus.src_b, signed_div)),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!acc_div)         state_d = ST_MUL;
          else if (acc_div_zero) state_d = ST_DONE;
          else                   state_d = ST_DIV;
        end
      end
      ST_MUL:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DIV:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  always_comb begin
    bus.stall_o  = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
    bus.busy     = (state_q != ST_IDLE);
    bus.hilo_we  = (state_q == ST_DONE) && !bus.flush;
    bus.div_zero = (state_q == ST_DONE) && !bus.flush && dz_q;
    bus.hi_o     = hi_q;
    bus.lo_o     = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
    end else if (accept) begin
      cnt_q        <= acc_div ? CNT_W'(DIV_ITER - 1) : CNT_W'(MUL_CYCLES - 1);
      a_q          <= bus.src_a;
      b_q          <= bus.src_b;
      mul_signed_q <= (bus.op == MDU_MULT);
      neg_quo_q    <= signed_div && (bus.src_a[31] ^ bus.src_b[31]);
      neg_rem_q    <= signed_div && bus.src_a[31];
    end else if (((state_q == ST_MUL) || (state_q == ST_DIV)) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Results only change on a real entry into DONE, so HI/LO hold across flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
    end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      unique case (state_q)
        ST_IDLE: begin
          hi_q <= bus.src_a;
          lo_q <= 32'hFFFF_FFFF;
          dz_q <= 1'b1;
        end
        ST_MUL: begin
          hi_q <= product[63:32];
          lo_q <= product[31:0];
          dz_q <= 1'b0;
        end
        ST_DIV: begin
          hi_q <= neg_rem_q ? (~div_rem + 32'd1) : div_rem;
          lo_q <= neg_quo_q ? (~div_quo + 32'd1) : div_quo;
          dz_q <= 1'b0;
        end
        default: dz_q <= 1'b0;
      endcase
    end
  end

endmodule
